// File: rtl/hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// hazard_unit_pkg : stage indices, forward-select codes, control FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_unit_pkg;

  localparam int STG_IF     = 0;
  localparam int STG_ID     = 1;
  localparam int STG_EX     = 2;
  localparam int STG_MEM    = 3;
  localparam int STG_WB     = 4;
  localparam int NUM_STAGES = 5;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDSTALL = 2'd1,
    ST_FLUSH   = 2'd2
  } hu_state_e;

endpackage

`default_nettype wire

// File: rtl/hazard_unit_fwd_mux.sv
// ---------------------------------------------------------------------------
// hazard_unit_fwd_mux : match-and-select forwarding for one source operand
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_unit_fwd_mux
  import hazard_unit_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 32,
  parameter int FWD_EN = 1
) (
  input  logic [AWIDTH-1:0] rs,
  input  logic [DWIDTH-1:0] rf_data,
  input  logic              ex_valid,
  input  logic              ex_we,
  input  logic              ex_is_load,
  input  logic [AWIDTH-1:0] ex_rd,
  input  logic [DWIDTH-1:0] ex_data,
  input  logic              mem_valid,
  input  logic              mem_we,
  input  logic [AWIDTH-1:0] mem_rd,
  input  logic [DWIDTH-1:0] mem_data,
  input  logic              wb_we,
  input  logic [AWIDTH-1:0] wb_rd,
  input  logic [DWIDTH-1:0] wb_data,
  output logic [1:0]        sel,
  output logic [DWIDTH-1:0] data,
  output logic              load_use,
  output logic              interlock
);

  logic w_rs_nz;
  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  // x0 is hard-wired zero, so it never matches a producer
  assign w_rs_nz   = |rs;
  assign w_ex_hit  = w_rs_nz & ex_valid & ex_we & (ex_rd == rs);
  assign w_mem_hit = w_rs_nz & mem_valid & mem_we & (mem_rd == rs);
  assign w_wb_hit  = w_rs_nz & wb_we & (wb_rd == rs);

  assign load_use  = w_ex_hit & ex_is_load;
  assign interlock = (FWD_EN == 0) & (w_ex_hit | w_mem_hit);

  always_comb begin
    sel  = FWD_RF;
    data = rf_data;
    if ((FWD_EN != 0) && w_ex_hit && !ex_is_load) begin
      sel  = FWD_EX;
      data = ex_data;
    end else if ((FWD_EN != 0) && w_mem_hit) begin
      sel  = FWD_MEM;
      data = mem_data;
    end else if (w_wb_hit) begin
      sel  = FWD_WB;
      data = wb_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit : pipeline stall/flush control, forwarding, PC redirect, counters
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int AWIDTH       = 5,
  parameter int DWIDTH       = 32,
  parameter int PC_WIDTH     = 32,
  parameter int FWD_EN       = 1,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                  hu_clk,
  input  logic                  hu_rst,
  input  logic                  hu_i_ds_valid,
  input  logic [AWIDTH-1:0]     hu_i_ds_rs1,
  input  logic [AWIDTH-1:0]     hu_i_ds_rs2,
  input  logic [DWIDTH-1:0]     hu_i_rf_rs1,
  input  logic [DWIDTH-1:0]     hu_i_rf_rs2,
  input  logic                  hu_i_ex_valid,
  input  logic                  hu_i_ex_we,
  input  logic                  hu_i_ex_is_load,
  input  logic [AWIDTH-1:0]     hu_i_ex_rd,
  input  logic [DWIDTH-1:0]     hu_i_ex_data,
  input  logic                  hu_i_mem_valid,
  input  logic                  hu_i_mem_we,
  input  logic [AWIDTH-1:0]     hu_i_mem_rd,
  input  logic [DWIDTH-1:0]     hu_i_mem_data,
  input  logic                  hu_i_wb_we,
  input  logic [AWIDTH-1:0]     hu_i_wb_rd,
  input  logic [DWIDTH-1:0]     hu_i_wb_data,
  input  logic                  hu_i_alu_busy,
  input  logic                  hu_i_mem_busy,
  input  logic                  hu_i_change_pc,
  input  logic [PC_WIDTH-1:0]   hu_i_next_pc,
  output logic [4:0]            hu_o_stall,
  output logic [4:0]            hu_o_flush,
  output logic [1:0]            hu_o_fwd_rs1_sel,
  output logic [1:0]            hu_o_fwd_rs2_sel,
  output logic [DWIDTH-1:0]     hu_o_fwd_rs1_data,
  output logic [DWIDTH-1:0]     hu_o_fwd_rs2_data,
  output logic                  hu_o_redirect,
  output logic [PC_WIDTH-1:0]   hu_o_redirect_pc,
  output logic [CNT_WIDTH-1:0]  hu_o_stall_cnt,
  output logic [CNT_WIDTH-1:0]  hu_o_flush_cnt
);

  localparam int         FCW        = 3;
  localparam logic [2:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  hu_state_e               r_state, w_state_nxt;
  logic [FCW-1:0]          r_fcnt, w_fcnt_nxt;
  logic                    r_redirect;
  logic [PC_WIDTH-1:0]     r_redirect_pc;
  logic [CNT_WIDTH-1:0]    r_stall_cnt;
  logic [CNT_WIDTH-1:0]    r_flush_cnt;
  logic [NUM_STAGES-1:0]   w_stall;
  logic [NUM_STAGES-1:0]   w_flush;
  logic                    w_accept;
  logic                    w_lu1, w_lu2, w_il1, w_il2;
  logic                    w_load_use;
  logic                    w_hazard;

  hazard_unit_fwd_mux #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .FWD_EN(FWD_EN)) u_fwd_rs1 (
    .rs        (hu_i_ds_rs1),
    .rf_data   (hu_i_rf_rs1),
    .ex_valid  (hu_i_ex_valid),
    .ex_we     (hu_i_ex_we),
    .ex_is_load(hu_i_ex_is_load),
    .ex_rd     (hu_i_ex_rd),
    .ex_data   (hu_i_ex_data),
    .mem_valid (hu_i_mem_valid),
    .mem_we    (hu_i_mem_we),
    .mem_rd    (hu_i_mem_rd),
    .mem_data  (hu_i_mem_data),
    .wb_we     (hu_i_wb_we),
    .wb_rd     (hu_i_wb_rd),
    .wb_data   (hu_i_wb_data),
    .sel       (hu_o_fwd_rs1_sel),
    .data      (hu_o_fwd_rs1_data),
    .load_use  (w_lu1),
    .interlock (w_il1)
  );

  hazard_unit_fwd_mux #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH), .FWD_EN(FWD_EN)) u_fwd_rs2 (
    .rs        (hu_i_ds_rs2),
    .rf_data   (hu_i_rf_rs2),
    .ex_valid  (hu_i_ex_valid),
    .ex_we     (hu_i_ex_we),
    .ex_is_load(hu_i_ex_is_load),
    .ex_rd     (hu_i_ex_rd),
    .ex_data   (hu_i_ex_data),
    .mem_valid (hu_i_mem_valid),
    .mem_we    (hu_i_mem_we),
    .mem_rd    (hu_i_mem_rd),
    .mem_data  (hu_i_mem_data),
    .wb_we     (hu_i_wb_we),
    .wb_rd     (hu_i_wb_rd),
    .wb_data   (hu_i_wb_data),
    .sel       (hu_o_fwd_rs2_sel),
    .data      (hu_o_fwd_rs2_data),
    .load_use  (w_lu2),
    .interlock (w_il2)
  );

  // The load that caused LDSTALL is still in EX for one cycle; don't re-raise it
  assign w_load_use = hu_i_ds_valid & (w_lu1 | w_lu2) & (r_state != ST_LDSTALL);
  assign w_hazard   = w_load_use | (hu_i_ds_valid & (w_il1 | w_il2));

  always_comb begin
    w_stall     = '0;
    w_flush     = '0;
    w_accept    = 1'b0;
    w_state_nxt = r_state;
    w_fcnt_nxt  = r_fcnt;
    if (hu_i_mem_busy) begin
      w_stall[STG_IF]  = 1'b1;
      w_stall[STG_ID]  = 1'b1;
      w_stall[STG_EX]  = 1'b1;
      w_stall[STG_MEM] = 1'b1;
    end else if (hu_i_alu_busy) begin
      w_stall[STG_IF]  = 1'b1;
      w_stall[STG_ID]  = 1'b1;
      w_stall[STG_EX]  = 1'b1;
      w_flush[STG_MEM] = 1'b1;
    end else if (hu_i_change_pc) begin
      w_accept        = 1'b1;
      w_flush[STG_IF] = 1'b1;
      w_flush[STG_ID] = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = ST_FLUSH;
        w_fcnt_nxt  = FLUSH_LOAD;
      end else begin
        w_state_nxt = ST_RUN;
      end
    end else if (r_state == ST_FLUSH) begin
      w_flush[STG_IF] = 1'b1;
      w_flush[STG_ID] = 1'b1;
      w_fcnt_nxt      = r_fcnt - 1'b1;
      if (r_fcnt <= 3'd1) begin
        w_state_nxt = ST_RUN;
      end
    end else if (w_hazard) begin
      w_stall[STG_IF] = 1'b1;
      w_stall[STG_ID] = 1'b1;
      w_flush[STG_EX] = 1'b1;
      w_state_nxt     = w_load_use ? ST_LDSTALL : ST_RUN;
    end else begin
      w_state_nxt = ST_RUN;
    end
  end

  always_ff @(posedge hu_clk or negedge hu_rst) begin
    if (!hu_rst) begin
      r_state       <= ST_RUN;
      r_fcnt        <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_stall_cnt   <= '0;
      r_flush_cnt   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fcnt     <= w_fcnt_nxt;
      r_redirect <= w_accept;
      if (w_accept) begin
        r_redirect_pc <= hu_i_next_pc;
      end
      if (w_stall[STG_ID] && (r_stall_cnt != {CNT_WIDTH{1'b1}})) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
      if (w_accept && (r_flush_cnt != {CNT_WIDTH{1'b1}})) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end
  end

  assign hu_o_stall       = w_stall;
  assign hu_o_flush       = w_flush;
  assign hu_o_redirect    = r_redirect;
  assign hu_o_redirect_pc = r_redirect_pc;
  assign hu_o_stall_cnt   = r_stall_cnt;
  assign hu_o_flush_cnt   = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit : directed checks of hazard_unit (forwarding, no-fwd, 4-bit counters)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_unit;

  logic        hu_clk;
  logic        hu_rst;
  logic        ds_valid;
  logic [4:0]  ds_rs1, ds_rs2;
  logic [31:0] rf_rs1, rf_rs2;
  logic        ex_valid, ex_we, ex_is_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        mem_valid, mem_we;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        alu_busy, mem_busy, change_pc;
  logic [31:0] next_pc;

  logic [4:0]  a_stall, a_flush, b_stall, b_flush, c_stall, c_flush;
  logic [1:0]  a_s1, a_s2, b_s1, b_s2, c_s1, c_s2;
  logic [31:0] a_d1, a_d2, b_d1, b_d2, c_d1, c_d2;
  logic        a_redir, b_redir, c_redir;
  logic [31:0] a_rpc, b_rpc, c_rpc;
  logic [15:0] a_scnt, a_fcnt, b_scnt, b_fcnt;
  logic [3:0]  c_scnt, c_fcnt;

  int n_pass  = 0;
  int n_total = 0;

  initial hu_clk = 1'b0;
  always #5 hu_clk = ~hu_clk;

  // u_a: full forwarding; u_b: no forwarding; u_c: 4-bit counters
  hazard_unit #(.FWD_EN(1), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) u_a (
    .hu_clk(hu_clk), .hu_rst(hu_rst), .hu_i_ds_valid(ds_valid),
    .hu_i_ds_rs1(ds_rs1), .hu_i_ds_rs2(ds_rs2), .hu_i_rf_rs1(rf_rs1), .hu_i_rf_rs2(rf_rs2),
    .hu_i_ex_valid(ex_valid), .hu_i_ex_we(ex_we), .hu_i_ex_is_load(ex_is_load),
    .hu_i_ex_rd(ex_rd), .hu_i_ex_data(ex_data),
    .hu_i_mem_valid(mem_valid), .hu_i_mem_we(mem_we), .hu_i_mem_rd(mem_rd), .hu_i_mem_data(mem_data),
    .hu_i_wb_we(wb_we), .hu_i_wb_rd(wb_rd), .hu_i_wb_data(wb_data),
    .hu_i_alu_busy(alu_busy), .hu_i_mem_busy(mem_busy),
    .hu_i_change_pc(change_pc), .hu_i_next_pc(next_pc),
    .hu_o_stall(a_stall), .hu_o_flush(a_flush),
    .hu_o_fwd_rs1_sel(a_s1), .hu_o_fwd_rs2_sel(a_s2),
    .hu_o_fwd_rs1_data(a_d1), .hu_o_fwd_rs2_data(a_d2),
    .hu_o_redirect(a_redir), .hu_o_redirect_pc(a_rpc),
    .hu_o_stall_cnt(a_scnt), .hu_o_flush_cnt(a_fcnt)
  );

  hazard_unit #(.FWD_EN(0), .FLUSH_CYCLES(2), .CNT_WIDTH(16)) u_b (
    .hu_clk(hu_clk), .hu_rst(hu_rst), .hu_i_ds_valid(ds_valid),
    .hu_i_ds_rs1(ds_rs1), .hu_i_ds_rs2(ds_rs2), .hu_i_rf_rs1(rf_rs1), .hu_i_rf_rs2(rf_rs2),
    .hu_i_ex_valid(ex_valid), .hu_i_ex_we(ex_we), .hu_i_ex_is_load(ex_is_load),
    .hu_i_ex_rd(ex_rd), .hu_i_ex_data(ex_data),
    .hu_i_mem_valid(mem_valid), .hu_i_mem_we(mem_we), .hu_i_mem_rd(mem_rd), .hu_i_mem_data(mem_data),
    .hu_i_wb_we(wb_we), .hu_i_wb_rd(wb_rd), .hu_i_wb_data(wb_data),
    .hu_i_alu_busy(alu_busy), .hu_i_mem_busy(mem_busy),
    .hu_i_change_pc(change_pc), .hu_i_next_pc(next_pc),
    .hu_o_stall(b_stall), .hu_o_flush(b_flush),
    .hu_o_fwd_rs1_sel(b_s1), .hu_o_fwd_rs2_sel(b_s2),
    .hu_o_fwd_rs1_data(b_d1), .hu_o_fwd_rs2_data(b_d2),
    .hu_o_redirect(b_redir), .hu_o_redirect_pc(b_rpc),
    .hu_o_stall_cnt(b_scnt), .hu_o_flush_cnt(b_fcnt)
  );

  hazard_unit #(.FWD_EN(1), .FLUSH_CYCLES(2), .CNT_WIDTH(4)) u_c (
    .hu_clk(hu_clk), .hu_rst(hu_rst), .hu_i_ds_valid(ds_valid),
    .hu_i_ds_rs1(ds_rs1), .hu_i_ds_rs2(ds_rs2), .hu_i_rf_rs1(rf_rs1), .hu_i_rf_rs2(rf_rs2),
    .hu_i_ex_valid(ex_valid), .hu_i_ex_we(ex_we), .hu_i_ex_is_load(ex_is_load),
    .hu_i_ex_rd(ex_rd), .hu_i_ex_data(ex_data),
    .hu_i_mem_valid(mem_valid), .hu_i_mem_we(mem_we), .hu_i_mem_rd(mem_rd), .hu_i_mem_data(mem_data),
    .hu_i_wb_we(wb_we), .hu_i_wb_rd(wb_rd), .hu_i_wb_data(wb_data),
    .hu_i_alu_busy(alu_busy), .hu_i_mem_busy(mem_busy),
    .hu_i_change_pc(change_pc), .hu_i_next_pc(next_pc),
    .hu_o_stall(c_stall), .hu_o_flush(c_flush),
    .hu_o_fwd_rs1_sel(c_s1), .hu_o_fwd_rs2_sel(c_s2),
    .hu_o_fwd_rs1_data(c_d1), .hu_o_fwd_rs2_data(c_d2),
    .hu_o_redirect(c_redir), .hu_o_redirect_pc(c_rpc),
    .hu_o_stall_cnt(c_scnt), .hu_o_flush_cnt(c_fcnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge hu_clk);
    #1;
  endtask

  task automatic idle();
    ds_valid = 0; ds_rs1 = 0; ds_rs2 = 0; rf_rs1 = 32'hDEAD_0001; rf_rs2 = 32'hDEAD_0002;
    ex_valid = 0; ex_we = 0; ex_is_load = 0; ex_rd = 0; ex_data = 0;
    mem_valid = 0; mem_we = 0; mem_rd = 0; mem_data = 0;
    wb_we = 0; wb_rd = 0; wb_data = 0;
    alu_busy = 0; mem_busy = 0; change_pc = 0; next_pc = 0;
  endtask

  task automatic do_reset();
    idle();
    hu_rst = 1'b0;
    tick();
    tick();
    hu_rst = 1'b1;
  endtask

  task automatic set_load_use();
    ds_valid = 1; ds_rs2 = 5'd7;
    ex_valid = 1; ex_we = 1; ex_is_load = 1; ex_rd = 5'd7; ex_data = 32'hBAD;
  endtask

  initial begin
    hu_rst = 1'b1;
    idle();
    #2;
    hu_rst = 1'b0;
    #1;
    check("rst_stall", {27'd0, a_stall}, 32'd0);
    check("rst_flush", {27'd0, a_flush}, 32'd0);
    check("rst_redirect", {31'd0, a_redir}, 32'd0);
    check("rst_redirect_pc", a_rpc, 32'd0);
    check("rst_stall_cnt", {16'd0, a_scnt}, 32'd0);
    check("rst_flush_cnt", {28'd0, c_fcnt}, 32'd0);
    do_reset();

    // EX forwarding has priority over MEM; x0 never forwards
    ds_valid = 1; ds_rs1 = 5'd5;
    ex_valid = 1; ex_we = 1; ex_rd = 5'd5; ex_data = 32'h11;
    mem_valid = 1; mem_we = 1; mem_rd = 5'd5; mem_data = 32'h22;
    #1;
    check("ex_fwd_sel1", {30'd0, a_s1}, 32'd1);
    check("ex_fwd_data1", a_d1, 32'h11);
    check("ex_fwd_nostall", {27'd0, a_stall}, 32'd0);
    ds_rs1 = 5'd0;
    #1;
    check("x0_sel1", {30'd0, a_s1}, 32'd0);
    check("x0_data1", a_d1, 32'hDEAD_0001);
    ex_valid = 0; ds_rs2 = 5'd5; wb_we = 1; wb_rd = 5'd9; wb_data = 32'h99; ds_rs1 = 5'd9;
    #1;
    check("mem_fwd_sel2", {30'd0, a_s2}, 32'd2);
    check("mem_fwd_data2", a_d2, 32'h22);
    check("wb_fwd_sel1", {30'd0, a_s1}, 32'd3);
    check("wb_fwd_data1", a_d1, 32'h99);

    // load-use: one bubble, not re-raised in LDSTALL, MEM forwards afterwards
    do_reset();
    set_load_use();
    #1;
    check("lu_stall", {27'd0, a_stall}, 32'b00011);
    check("lu_flush", {27'd0, a_flush}, 32'b00100);
    check("lu_sel2", {30'd0, a_s2}, 32'd0);
    tick();
    mem_valid = 1; mem_we = 1; mem_rd = 5'd7; mem_data = 32'h77;
    #1;
    check("lu_release_stall", {27'd0, a_stall}, 32'd0);
    check("lu_release_flush", {27'd0, a_flush}, 32'd0);
    check("lu_mem_sel2", {30'd0, a_s2}, 32'd2);
    check("lu_mem_data2", a_d2, 32'h77);
    check("lu_stall_cnt", {16'd0, a_scnt}, 32'd1);
    tick();
    check("lu_rearm_stall", {27'd0, a_stall}, 32'b00011);

    // no-forwarding interlock: stall while x3 is in EX then MEM, WB bypass after
    do_reset();
    ds_valid = 1; ds_rs1 = 5'd3; rf_rs1 = 32'h5;
    ex_valid = 1; ex_we = 1; ex_rd = 5'd3; ex_data = 32'h33;
    #1;
    check("nf_ex_stall", {27'd0, b_stall}, 32'b00011);
    check("nf_ex_sel1", {30'd0, b_s1}, 32'd0);
    tick();
    ex_valid = 0; mem_valid = 1; mem_we = 1; mem_rd = 5'd3; mem_data = 32'h33;
    #1;
    check("nf_mem_stall", {27'd0, b_stall}, 32'b00011);
    check("nf_mem_flush", {27'd0, b_flush}, 32'b00100);
    tick();
    mem_valid = 0; wb_we = 1; wb_rd = 5'd3; wb_data = 32'h33;
    #1;
    check("nf_wb_stall", {27'd0, b_stall}, 32'd0);
    check("nf_wb_sel1", {30'd0, b_s1}, 32'd3);
    check("nf_wb_data1", b_d1, 32'h33);
    check("nf_stall_cnt", {16'd0, b_scnt}, 32'd2);

    // redirect with two flush cycles; a concurrent load-use hazard is dropped
    do_reset();
    set_load_use();
    change_pc = 1; next_pc = 32'h100;
    #1;
    check("pc_flush0", {27'd0, a_flush}, 32'b00011);
    check("pc_stall0", {27'd0, a_stall}, 32'd0);
    check("pc_redir0", {31'd0, a_redir}, 32'd0);
    tick();
    idle();
    #1;
    check("pc_flush1", {27'd0, a_flush}, 32'b00011);
    check("pc_redir1", {31'd0, a_redir}, 32'd1);
    check("pc_redir_pc1", a_rpc, 32'h100);
    check("pc_flush_cnt1", {16'd0, a_fcnt}, 32'd1);
    tick();
    check("pc_flush2", {27'd0, a_flush}, 32'd0);
    check("pc_redir2", {31'd0, a_redir}, 32'd0);
    change_pc = 1; next_pc = 32'h180;
    tick();
    next_pc = 32'h200;
    #1;
    check("pc_reload_flush", {27'd0, a_flush}, 32'b00011);
    check("pc_reload_pc_a", a_rpc, 32'h180);
    tick();
    idle();
    #1;
    check("pc_reload_hold", {27'd0, a_flush}, 32'b00011);
    check("pc_reload_redir", {31'd0, a_redir}, 32'd1);
    check("pc_reload_pc_b", a_rpc, 32'h200);
    check("pc_flush_cnt3", {16'd0, a_fcnt}, 32'd3);
    tick();
    check("pc_reload_done", {27'd0, a_flush}, 32'd0);

    // busy priority over change_pc
    mem_busy = 1; alu_busy = 1; change_pc = 1; next_pc = 32'h300;
    #1;
    check("mb_stall", {27'd0, a_stall}, 32'b01111);
    check("mb_flush", {27'd0, a_flush}, 32'd0);
    tick();
    check("mb_noredir", {31'd0, a_redir}, 32'd0);
    mem_busy = 0;
    #1;
    check("ab_stall", {27'd0, a_stall}, 32'b00111);
    check("ab_flush", {27'd0, a_flush}, 32'b01000);
    tick();
    check("ab_noredir", {31'd0, a_redir}, 32'd0);
    check("busy_flush_cnt", {16'd0, a_fcnt}, 32'd3);
    idle();

    // asynchronous reset in the middle of FLUSH and LDSTALL
    change_pc = 1; next_pc = 32'h140;
    tick();
    idle();
    #2;
    hu_rst = 1'b0;
    #1;
    check("arst_flush_redir", {31'd0, a_redir}, 32'd0);
    check("arst_flush_pc", a_rpc, 32'd0);
    check("arst_flush_cnt", {16'd0, a_fcnt}, 32'd0);
    check("arst_flush_vec", {27'd0, a_flush}, 32'd0);
    #2;
    hu_rst = 1'b1;
    #1;
    check("arst_run_flush", {27'd0, a_flush}, 32'd0);
    tick();
    set_load_use();
    tick();
    check("ld_in_ldstall", {27'd0, a_stall}, 32'd0);
    #2;
    hu_rst = 1'b0;
    #1;
    check("arst_ld_scnt", {16'd0, a_scnt}, 32'd0);
    #2;
    hu_rst = 1'b1;
    #1;
    check("arst_ld_run", {27'd0, a_stall}, 32'b00011);

    // 4-bit counters saturate at 15; the 16-bit ones keep counting
    do_reset();
    change_pc = 1; next_pc = 32'h400;
    for (int i = 0; i < 14; i++) tick();
    check("sat_fcnt14", {28'd0, c_fcnt}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_fcnt15", {28'd0, c_fcnt}, 32'd15);
    check("wide_fcnt20", {16'd0, a_fcnt}, 32'd20);
    idle();
    mem_busy = 1;
    for (int i = 0; i < 14; i++) tick();
    check("sat_scnt14", {28'd0, c_scnt}, 32'd14);
    for (int i = 0; i < 6; i++) tick();
    check("sat_scnt15", {28'd0, c_scnt}, 32'd15);
    idle();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
